// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg: shared state encoding and hex-to-segment table for the 7-segment scanner
package sevenseg_pkg;
  typedef enum logic {BLANK, SCAN} state_t;
  localparam logic [6:0] SEG_OFF = 7'b0000000;
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: hex_to_seg = 7'b1111110;
      4'h1: hex_to_seg = 7'b0110000;
      4'h2: hex_to_seg = 7'b1101101;
      4'h3: hex_to_seg = 7'b1111001;
      4'h4: hex_to_seg = 7'b0110011;
      4'h5: hex_to_seg = 7'b1011011;
      4'h6: hex_to_seg = 7'b1011111;
      4'h7: hex_to_seg = 7'b1110000;
      4'h8: hex_to_seg = 7'b1111111;
      4'h9: hex_to_seg = 7'b1111011;
      4'ha: hex_to_seg = 7'b1110111;
      4'hb: hex_to_seg = 7'b0011111;
      4'hc: hex_to_seg = 7'b1001110;
      4'hd: hex_to_seg = 7'b0111101;
      4'he: hex_to_seg = 7'b1001111;
      4'hf: hex_to_seg = 7'b1000111;
    endcase
  endfunction
endpackage

// File: rtl/sevenseg_scan_decode.sv
// seg_hex_decode: combinational nibble to {a..g} segment decoder
module seg_hex_decode
  import sevenseg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  assign seg = hex_to_seg(hex);
endmodule

// File: rtl/sevenseg_scan.sv
// sevenseg_scan: multiplexed 7-segment driver with frame-aligned shadow update,
// guard blanking between digits and optional leading-zero suppression
module sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int DIGITS           = 4,
  parameter int PRESCALE         = 1000,
  parameter int GUARD            = 2,
  parameter bit ANODE_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [4*DIGITS-1:0]   load_data,
  input  logic                  blank_lead,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [DIGITS-1:0] AN_OFF = ANODE_ACTIVE_LOW ? '1 : '0;
  state_t state;
  logic [PW-1:0] cnt;
  logic [IW-1:0] idx;
  logic pending, wrap, term, accept, guard, z;
  logic [4*DIGITS-1:0] pend_data, shown;
  logic [3:0] nib;
  logic [6:0] dec;
  logic [DIGITS-1:0] supp, onehot, an_on;
  assign load_ready = !pending;
  assign accept = load_valid && load_ready;
  assign wrap = cnt == PW'(PRESCALE - 1);
  assign term = wrap && idx == IW'(DIGITS - 1);
  assign guard = cnt < PW'(GUARD);
  assign nib = shown[{idx, 2'b00} +: 4];
  assign onehot = DIGITS'(1) << idx;
  assign an_on = ANODE_ACTIVE_LOW ? ~onehot : onehot;
  // a digit is blankable only if it and every more significant nibble are zero
  always_comb begin
    supp = '0;
    z = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      z = z && shown[4*i +: 4] == 4'h0;
      supp[i] = z;
    end
  end
  seg_hex_decode u_dec (.hex(nib), .seg(dec));
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= BLANK;
      cnt        <= '0;
      idx        <= '0;
      pending    <= 1'b0;
      pend_data  <= '0;
      shown      <= '0;
      seg        <= SEG_OFF;
      an         <= AN_OFF;
      frame_done <= 1'b0;
    end else if (state == BLANK) begin
      seg        <= SEG_OFF;
      an         <= AN_OFF;
      frame_done <= 1'b0;
      if (accept) begin
        shown <= load_data;
        state <= SCAN;
      end
    end else begin
      cnt        <= wrap ? '0 : cnt + 1'b1;
      if (wrap) idx <= idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1;
      seg        <= guard || (blank_lead && supp[idx]) ? SEG_OFF : dec;
      an         <= guard ? AN_OFF : an_on;
      frame_done <= term;
      // accept implies nothing pending, so a same-edge load waits for the next boundary
      if (accept) begin
        pend_data <= load_data;
        pending   <= 1'b1;
      end else if (term && pending) begin
        shown   <= pend_data;
        pending <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sevenseg_scan.sv
// tb_sevenseg_scan: table vectors, directed corner sequences and random traffic vs a frame-time model
module tb_sevenseg_scan;
  logic clk = 0, rst_n = 0, load_valid = 0, blank_lead = 0;
  logic [15:0] load_data = '0;
  logic load_ready, frame_done;
  logic [6:0] seg;
  logic [3:0] an;
  int compared = 0, mismatched = 0;
  bit chk_en = 0;
  always #5 clk = ~clk;
  sevenseg_scan #(.DIGITS(4), .PRESCALE(4), .GUARD(1), .ANODE_ACTIVE_LOW(1)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .blank_lead(blank_lead), .seg(seg), .an(an), .frame_done(frame_done)
  );
  logic [6:0] tbl [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 7'b1011011,
                           7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                           7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // Reference: time since the scan started; 4-cycle slots, 16-cycle frames
  bit m_scan = 0;
  int m_n = 0;
  logic [15:0] m_shown = '0;
  logic [15:0] m_pend [$];
  logic [6:0] e_seg = '0;
  logic [3:0] e_an = 4'hF;
  logic e_fd = 0, e_rdy = 1;
  always @(posedge clk) begin
    if (!rst_n) begin
      m_scan = 0; m_n = 0; m_shown = '0; m_pend.delete();
      e_seg = '0; e_an = 4'hF; e_fd = 0;
    end else begin
      bit acc;
      int slot, dig;
      logic [3:0] nb;
      acc = load_valid && m_pend.size() == 0;
      if (!m_scan) begin
        e_seg = '0; e_an = 4'hF; e_fd = 0;
        if (acc) begin m_shown = load_data; m_scan = 1; m_n = 0; end
      end else begin
        slot = m_n % 4;
        dig = (m_n / 4) % 4;
        nb = 4'(m_shown >> (4 * dig));
        e_an = slot < 1 ? 4'hF : ~(4'b1 << dig);
        e_seg = (slot < 1 || (blank_lead && dig > 0 && (m_shown >> (4 * dig)) == 0)) ? 7'd0 : tbl[nb];
        e_fd = (m_n % 16) == 15;
        if (acc) m_pend.push_back(load_data);
        else if (e_fd && m_pend.size() > 0) m_shown = m_pend.pop_front();
        m_n++;
      end
    end
    e_rdy = m_pend.size() == 0;
  end
  always @(negedge clk) if (chk_en) begin
    chk("model_seg", seg, e_seg);
    chk("model_an", an, e_an);
    chk("model_frame_done", frame_done, e_fd);
    chk("model_load_ready", load_ready, e_rdy);
  end
  typedef struct {
    logic [15:0] data;
    logic bl;
    logic [3:0][6:0] s;
  } vec_t;
  vec_t vt [6];
  task automatic wait_fd();
    int k = 0;
    do begin @(negedge clk); k++; end while (!frame_done && k < 40);
    chk("frame_done_timeout", frame_done, 1);
  endtask
  task automatic do_reset();
    rst_n = 0; load_valid = 0;
    @(negedge clk);
    rst_n = 1;
  endtask
  initial begin
    logic [3:0] ea;
    vt[0] = '{16'h1234, 1'b0, {7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011}};
    vt[1] = '{16'h0007, 1'b1, {7'b0000000, 7'b0000000, 7'b0000000, 7'b1110000}};
    vt[2] = '{16'h0000, 1'b1, {7'b0000000, 7'b0000000, 7'b0000000, 7'b1111110}};
    vt[3] = '{16'h0007, 1'b0, {7'b1111110, 7'b1111110, 7'b1111110, 7'b1110000}};
    vt[4] = '{16'h0A05, 1'b1, {7'b0000000, 7'b1110111, 7'b1111110, 7'b1011011}};
    vt[5] = '{16'hF08E, 1'b1, {7'b1000111, 7'b1111110, 7'b1111111, 7'b1001111}};
    @(negedge clk); @(negedge clk);
    chk_en = 1;
    chk("reset_an", an, 4'hF); chk("reset_seg", seg, 0); chk("reset_ready", load_ready, 1);
    rst_n = 1;
    repeat (100) begin
      @(negedge clk);
      chk("idle_an", an, 4'hF); chk("idle_seg", seg, 0); chk("idle_ready", load_ready, 1);
    end
    for (int i = 0; i < 6; i++) begin
      do_reset();
      blank_lead = vt[i].bl; load_data = vt[i].data; load_valid = 1;
      for (int n = 0; n < 16; n++) begin
        @(negedge clk);
        if (n == 0) load_valid = 0;
        if (n % 4 == 1) chk("vec_guard_an", an, 4'hF);
        if (n % 4 == 2) begin
          ea = ~(4'b1 << (n / 4));
          chk("vec_seg", seg, vt[i].s[n/4]);
          chk("vec_an", an, ea);
        end
      end
    end
    do_reset();
    blank_lead = 0; load_data = 16'h1234; load_valid = 1;
    @(negedge clk); load_valid = 0;
    wait_fd();
    repeat (5) @(negedge clk);
    load_data = 16'hABCD; load_valid = 1;
    @(negedge clk);
    load_valid = 0;
    chk("midload_ready_drop", load_ready, 0);
    wait_fd();
    chk("midload_ready_back", load_ready, 1);
    repeat (2) @(negedge clk);
    chk("midload_new_digit0", seg, 7'b0111101);
    wait_fd();
    repeat (15) @(negedge clk);
    load_data = 16'h5A5A; load_valid = 1;
    @(negedge clk);
    load_valid = 0;
    chk("term_fd", frame_done, 1);
    chk("term_ready_low", load_ready, 0);
    repeat (2) @(negedge clk);
    chk("term_old_digit0", seg, 7'b0111101);
    wait_fd();
    chk("term_ready_back", load_ready, 1);
    repeat (2) @(negedge clk);
    chk("term_new_digit0", seg, 7'b1110111);
    repeat (3) @(negedge clk);
    load_data = 16'h9999; load_valid = 1;
    @(negedge clk);
    load_valid = 0; rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("rst_mid_an", an, 4'hF); chk("rst_mid_seg", seg, 0); chk("rst_mid_ready", load_ready, 1);
    repeat (40) @(negedge clk);
    chk("rst_mid_blank_an", an, 4'hF); chk("rst_mid_blank_seg", seg, 0);
    for (int c = 0; c < 3000; c++) begin
      load_valid = $urandom_range(3) == 0;
      load_data = 16'($urandom);
      if ($urandom_range(7) == 0) blank_lead = ~blank_lead;
      rst_n = $urandom_range(499) != 0;
      @(negedge clk);
    end
    rst_n = 1; load_valid = 0;
    repeat (20) @(negedge clk);
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
